// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared constants and helpers for the mac_unit multiply-accumulate block.
//   MAC_DEFAULT_DATA_WIDTH : default operand width in bits
//   acc_width()            : accumulator / Cout width for a given operand width
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int unsigned MAC_DEFAULT_DATA_WIDTH = 8;

    // The accumulator is three operand widths wide: two for the full product
    // plus one operand width of headroom for repeated accumulation.
    function automatic int unsigned acc_width(input int unsigned data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// ---------------------------------------------------------------------------
// mac_mult
// Combinational unsigned DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH multiplier.
// Kept as its own module so it can later be pipelined or mapped to a DSP.
// Ports:
//   a, b    : unsigned operands, DATA_WIDTH bits
//   product : full-precision product, 2*DATA_WIDTH bits
// ---------------------------------------------------------------------------
module mac_mult
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MAC_DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;

    // Widen both operands first so the multiply is evaluated at full
    // product precision without relying on context-width rules.
    always_comb begin
        a_ext   = PW'(a);
        b_ext   = PW'(b);
        product = a_ext * b_ext;
    end

endmodule

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
// Unsigned multiply-accumulate. Each enabled cycle adds Ain*Bin into a
// registered 3*DATA_WIDTH accumulator that drives Cout directly.
// Priority per rising edge: rst > Clr > En > hold.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, zeroes the accumulator
//   En   : accumulate enable
//   Clr  : synchronous clear, wins over En
//   Ain  : operand A, unsigned, DATA_WIDTH bits
//   Bin  : operand B, unsigned, DATA_WIDTH bits
//   Cout : accumulator value, registered, 3*DATA_WIDTH bits
// Build option:
//   MAC_SATURATE_EN defined   -> accumulation saturates at all ones
//   MAC_SATURATE_EN undefined -> accumulation wraps modulo 2^(3*DATA_WIDTH)
// ---------------------------------------------------------------------------
module mac_unit
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MAC_DEFAULT_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                En,
    input  logic                                Clr,
    input  logic [DATA_WIDTH-1:0]               Ain,
    input  logic [DATA_WIDTH-1:0]               Bin,
    output logic [acc_width(DATA_WIDTH)-1:0]    Cout
);

    localparam int unsigned ACC_W = acc_width(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] product;
    logic [ACC_W-1:0]        product_ext;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;

    mac_mult #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .a       (Ain),
        .b       (Bin),
        .product (product)
    );

`ifdef MAC_SATURATE_EN
    logic [ACC_W:0] sum_full;

    // One extra bit catches the carry out; any carry means the true sum
    // exceeded the accumulator range, so clamp to all ones.
    always_comb begin
        product_ext = ACC_W'(product);
        sum_full    = {1'b0, acc} + {1'b0, product_ext};
        acc_sum     = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
    end
`else
    always_comb begin
        product_ext = ACC_W'(product);
        acc_sum     = acc + product_ext;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (Clr) begin
            acc <= '0;
        end else if (En) begin
            acc <= acc_sum;
        end
    end

    assign Cout = acc;

endmodule

// File: tb/tb_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_mac_unit
// Scoreboard bench for mac_unit at DATA_WIDTH = 8. Each driven cycle pushes
// the reference accumulator value; a monitor pops and compares after the
// following rising edge. Honours MAC_SATURATE_EN in the reference model.
// ---------------------------------------------------------------------------
module tb_mac_unit;

    localparam int unsigned DW    = 8;
    localparam int unsigned ACC_W = 3 * DW;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic             clk;
    logic             rst;
    logic             En;
    logic             Clr;
    logic [DW-1:0]    Ain;
    logic [DW-1:0]    Bin;
    logic [ACC_W-1:0] Cout;

    int unsigned checks;
    int unsigned errors;

    longint unsigned model_acc;
    longint unsigned sb_q[$];
    string           tag_q[$];
    string           cur_tag;

    mac_unit #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .En   (En),
        .Clr  (Clr),
        .Ain  (Ain),
        .Bin  (Bin),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    // Reference model update plus scoreboard push for one cycle of stimulus.
    task automatic drive(input string tag, input logic r, input logic c,
                         input logic e, input int unsigned a, input int unsigned b);
        longint unsigned sum;
        rst = r;
        Clr = c;
        En  = e;
        Ain = DW'(a);
        Bin = DW'(b);
        if (r || c) begin
            model_acc = 0;
        end else if (e) begin
            sum = model_acc + longint'(a) * longint'(b);
`ifdef MAC_SATURATE_EN
            model_acc = (sum > ACC_MAX) ? ACC_MAX : sum;
`else
            model_acc = sum & ACC_MAX;
`endif
        end
        sb_q.push_back(model_acc);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares one scoreboard entry per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                cur_tag = tag_q.pop_front();
                check(cur_tag, longint'(Cout), sb_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned drain;
        checks    = 0;
        errors    = 0;
        model_acc = 0;
        rst = 1'b1; Clr = 1'b0; En = 1'b0; Ain = '0; Bin = '0;

        drive("reset0",        1, 0, 0, 0, 0);
        drive("reset_hold",    1, 0, 1, 9, 9);
        drive("mac_2x2",       0, 0, 1, 2, 2);
        drive("hold_en0",      0, 0, 0, 77, 33);
        drive("mac_4x4",       0, 0, 1, 4, 4);
        drive("zero_operand",  0, 0, 1, 8, 0);
        drive("clr_with_en",   0, 1, 1, 5, 5);
        drive("mac_after_clr", 0, 0, 1, 3, 7);
        drive("b2b_1",         0, 0, 1, 10, 11);
        drive("b2b_2",         0, 0, 1, 12, 13);
        drive("rst_mid",       1, 0, 1, 200, 200);
        drive("rst_clr_both",  1, 1, 1, 1, 1);

        for (int i = 0; i < 16; i++) begin
            drive("random", 0, 0, ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 255), $urandom_range(0, 255));
        end

        drive("clr_pre_ovf", 0, 1, 0, 0, 0);
        for (int i = 0; i < 259; i++) begin
            drive("ovf_step", 0, 0, 1, 255, 255);
        end
`ifdef MAC_SATURATE_EN
        check("ovf_final_sat", longint'(Cout), 64'hFF_FFFF);
`else
        check("ovf_final_wrap", longint'(Cout), (64'd259 * 64'd65025) % (64'd1 << 24));
`endif
        drive("ovf_more",      0, 0, 1, 255, 255);
        drive("ovf_zero_op",   0, 0, 1, 0, 17);
        drive("ovf_hold",      0, 0, 0, 255, 255);
        drive("clr_post_ovf",  0, 1, 1, 255, 255);
        drive("mac_post_clr",  0, 0, 1, 255, 1);
        drive("idle",          0, 0, 0, 0, 0);

        drain = 0;
        while (sb_q.size() > 0 && drain < 8) begin
            @(posedge clk);
            #2;
            drain++;
        end
        check("scoreboard_drained", longint'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
